// File: rtl/my_interface.sv
// Shared opcode/select encodings and default datapath widths for the simd_pipe SIMD pipeline.
package my_interface;

  localparam int DEF_LANES  = 8;
  localparam int DEF_LANE_W = 64;
  localparam int DEF_PHIT_W = DEF_LANES * DEF_LANE_W;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MIN = 2'b10,
    OP_MAX = 2'b11
  } alu_op_e;

  // src0/src1 are in_data/in_aux at stage 0 and prev/prev-rotated at later stages
  typedef enum logic [1:0] {
    SEL_SRC0 = 2'b00,
    SEL_SRC1 = 2'b01,
    SEL_IMM  = 2'b10,
    SEL_RF   = 2'b11
  } opnd_sel_e;

endpackage

// File: rtl/simd_stage.sv
// One pipeline stage: operand muxes, per-lane ALUs, local register file and the beat register.
// Add/sub saturate when SIMD_PIPE_SAT_EN is defined and wrap otherwise.
module simd_stage
  import my_interface::*;
#(
  parameter int LANES    = DEF_LANES,
  parameter int LANE_W   = DEF_LANE_W,
  parameter int RF_DEPTH = 16,
  localparam int AW      = $clog2(RF_DEPTH),
  localparam int VW      = LANES * LANE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              up_valid_i,
  input  logic              capture_i,
  input  logic [VW-1:0]     src0_i,
  input  logic [VW-1:0]     src1_i,
  input  logic [LANE_W-1:0] imm_i,
  input  logic [3:0]        sel_i,
  input  logic [1:0]        op_i,
  input  logic              wen_i,
  input  logic [AW-1:0]     rd_addr_i,
  input  logic [AW-1:0]     wr_addr_i,
  output logic              valid_o,
  output logic [VW-1:0]     data_o
);

  localparam logic [LANE_W-1:0] S_MAX = {1'b0, {(LANE_W-1){1'b1}}};
  localparam logic [LANE_W-1:0] S_MIN = {1'b1, {(LANE_W-1){1'b0}}};

  logic          valid_q, valid_d;
  logic [VW-1:0] data_q, data_d;
  logic [VW-1:0] rf_q [RF_DEPTH];
  logic [VW-1:0] rf_rd, opa, opb, alu_res;
  logic          rf_we;

  function automatic logic [VW-1:0] pick(input logic [1:0] s, input logic [VW-1:0] a0,
                                         input logic [VW-1:0] a1, input logic [VW-1:0] im,
                                         input logic [VW-1:0] rf);
    case (opnd_sel_e'(s))
      SEL_SRC0: return a0;
      SEL_SRC1: return a1;
      SEL_IMM:  return im;
      default:  return rf;
    endcase
  endfunction

  function automatic logic [LANE_W-1:0] lane_alu(input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b, input alu_op_e op);
    logic [LANE_W-1:0] arith;
    logic              a_lt_b;
`ifdef SIMD_PIPE_SAT_EN
    logic [LANE_W:0]   ext;
    ext = (op == OP_SUB) ? {a[LANE_W-1], a} - {b[LANE_W-1], b}
                         : {a[LANE_W-1], a} + {b[LANE_W-1], b};
    // Sign bit and carry-out disagree only on overflow; the carry-out gives the direction.
    if (ext[LANE_W] != ext[LANE_W-1]) arith = ext[LANE_W] ? S_MIN : S_MAX;
    else                              arith = ext[LANE_W-1:0];
`else
    arith = (op == OP_SUB) ? a - b : a + b;
`endif
    a_lt_b = $signed(a) < $signed(b);
    case (op)
      OP_MIN:  return a_lt_b ? a : b;
      OP_MAX:  return a_lt_b ? b : a;
      default: return arith;
    endcase
  endfunction

  assign rf_rd = rf_q[rd_addr_i];
  assign opa   = pick(sel_i[1:0], src0_i, src1_i, {LANES{imm_i}}, rf_rd);
  assign opb   = pick(sel_i[3:2], src0_i, src1_i, {LANES{imm_i}}, rf_rd);

  always_comb begin
    alu_res = '0;
    for (int l = 0; l < LANES; l++) begin
      alu_res[l*LANE_W +: LANE_W] = lane_alu(opa[l*LANE_W +: LANE_W], opb[l*LANE_W +: LANE_W],
                                             alu_op_e'(op_i));
    end
  end

  // Bubbles clear valid but leave the data register untouched.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (capture_i) begin
      valid_d = up_valid_i;
      if (up_valid_i) data_d = alu_res;
    end
  end

  assign rf_we = capture_i && up_valid_i && wen_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[wr_addr_i] <= alu_res;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/simd_pipe.sv
// simd_pipe: NUM_STAGES-deep SIMD pipeline with collapsing bubbles and a register file per stage.
// Define SIMD_PIPE_SAT_EN for saturating add/sub; the default build wraps.
module simd_pipe
  import my_interface::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int LANES      = DEF_LANES,
  parameter int LANE_W     = DEF_LANE_W,
  parameter int RF_DEPTH   = 16,
  localparam int AW        = $clog2(RF_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*LANE_W-1:0]      in_data,
  input  logic [LANES*LANE_W-1:0]      in_aux,
  input  logic [NUM_STAGES*LANE_W-1:0] imm,
  input  logic [NUM_STAGES*4-1:0]      sel,
  input  logic [NUM_STAGES*2-1:0]      op,
  input  logic [NUM_STAGES-1:0]        wen_rf,
  input  logic [NUM_STAGES*AW-1:0]     rd_addr,
  input  logic [NUM_STAGES*AW-1:0]     wr_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*LANE_W-1:0]      out_data
);

  localparam int VW = LANES * LANE_W;

  logic [NUM_STAGES-1:0] valid_s;
  logic [NUM_STAGES-1:0] capture_s;
  logic [VW-1:0]         data_s [NUM_STAGES];

  // Ready ripples back from the output so any bubble ahead lets upstream stages advance.
  always_comb begin
    capture_s = '0;
    capture_s[NUM_STAGES-1] = !valid_s[NUM_STAGES-1] || out_ready;
    for (int s = NUM_STAGES - 2; s >= 0; s--) begin
      capture_s[s] = !valid_s[s] || capture_s[s+1];
    end
  end

  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    logic [VW-1:0] src0, src1;
    logic          up_valid;

    if (s == 0) begin : g_head
      assign src0     = in_data;
      assign src1     = in_aux;
      assign up_valid = in_valid;
    end else begin : g_body
      assign src0     = data_s[s-1];
      assign up_valid = valid_s[s-1];
      for (genvar l = 0; l < LANES; l++) begin : g_rot
        assign src1[l*LANE_W +: LANE_W] = data_s[s-1][((l + LANES - 1) % LANES)*LANE_W +: LANE_W];
      end
    end

    simd_stage #(
      .LANES   (LANES),
      .LANE_W  (LANE_W),
      .RF_DEPTH(RF_DEPTH)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .up_valid_i(up_valid),
      .capture_i (capture_s[s]),
      .src0_i    (src0),
      .src1_i    (src1),
      .imm_i     (imm[s*LANE_W +: LANE_W]),
      .sel_i     (sel[s*4 +: 4]),
      .op_i      (op[s*2 +: 2]),
      .wen_i     (wen_rf[s]),
      .rd_addr_i (rd_addr[s*AW +: AW]),
      .wr_addr_i (wr_addr[s*AW +: AW]),
      .valid_o   (valid_s[s]),
      .data_o    (data_s[s])
    );
  end

  assign in_ready  = capture_s[0];
  assign out_valid = valid_s[NUM_STAGES-1];
  assign out_data  = data_s[NUM_STAGES-1];

endmodule

// File: tb/tb_simd_pipe.sv
// Self-checking bench for simd_pipe: directed cases plus random traffic against a transaction-level model.
module tb_simd_pipe;

  localparam int NS = 4;
  localparam int LN = 8;
  localparam int LW = 64;
  localparam int RD = 16;
  localparam int AW = 4;
  localparam int VW = LN * LW;
  localparam int CYC_LIMIT = 3000;

  typedef logic [VW-1:0] vec_t;

  localparam logic [LW-1:0] MAXL = {1'b0, {(LW-1){1'b1}}};
  localparam logic [LW-1:0] MINL = {1'b1, {(LW-1){1'b0}}};
  localparam logic signed [127:0] SMAX = (128'sd1 <<< (LW - 1)) - 128'sd1;
  localparam logic signed [127:0] SMIN = -(128'sd1 <<< (LW - 1));

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic out_valid;
  logic out_ready = 1'b0;
  vec_t in_data = '0;
  vec_t in_aux = '0;
  vec_t out_data;
  logic [NS*LW-1:0] imm;
  logic [NS*4-1:0]  sel;
  logic [NS*2-1:0]  op;
  logic [NS-1:0]    wen_rf;
  logic [NS*AW-1:0] rd_addr, wr_addr;

  logic [3:0]    c_sel [NS];
  logic [1:0]    c_op  [NS];
  logic [LW-1:0] c_imm [NS];
  logic          c_wen [NS];
  logic [AW-1:0] c_rd  [NS];
  logic [AW-1:0] c_wr  [NS];

  vec_t mrf [NS][RD];
  vec_t stim_d[$], stim_a[$], exp_q[$], out_log[$];
  int   acc_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar s = 0; s < NS; s++) begin : g_cfg
    assign sel[s*4 +: 4]     = c_sel[s];
    assign op[s*2 +: 2]      = c_op[s];
    assign imm[s*LW +: LW]   = c_imm[s];
    assign wen_rf[s]         = c_wen[s];
    assign rd_addr[s*AW +: AW] = c_rd[s];
    assign wr_addr[s*AW +: AW] = c_wr[s];
  end

  simd_pipe #(.NUM_STAGES(NS), .LANES(LN), .LANE_W(LW), .RF_DEPTH(RD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_aux(in_aux), .imm(imm), .sel(sel), .op(op),
    .wen_rf(wen_rf), .rd_addr(rd_addr), .wr_addr(wr_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  task automatic chk(input string tag, input vec_t got, input vec_t exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  function automatic vec_t rep(input logic [LW-1:0] v);
    return {LN{v}};
  endfunction

  function automatic vec_t ramp(input int base);
    vec_t v;
    for (int i = 0; i < LN; i++) v[i*LW +: LW] = LW'(base + i);
    return v;
  endfunction

  function automatic logic [LW-1:0] rnd_lane();
    case ($urandom_range(5))
      0:       return MAXL;
      1:       return MINL;
      2:       return LW'($urandom_range(20));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic vec_t rnd_vec();
    vec_t v;
    for (int i = 0; i < LN; i++) v[i*LW +: LW] = rnd_lane();
    return v;
  endfunction

  // Lane arithmetic done on wide signed integers, then clamped or truncated to LW bits.
  function automatic logic [LW-1:0] alu_ref(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                            input logic [1:0] o);
    logic signed [127:0] sa, sb, r;
    sa = {{64{a[LW-1]}}, a};
    sb = {{64{b[LW-1]}}, b};
    case (o)
      2'b00:   r = sa + sb;
      2'b01:   r = sa - sb;
      2'b10:   r = (sa < sb) ? sa : sb;
      default: r = (sa < sb) ? sb : sa;
    endcase
`ifdef SIMD_PIPE_SAT_EN
    if (o[1] == 1'b0) begin
      if (r > SMAX) r = SMAX;
      else if (r < SMIN) r = SMIN;
    end
`endif
    return r[LW-1:0];
  endfunction

  function automatic vec_t operand(input logic [1:0] s, input vec_t p0, input vec_t p1,
                                   input vec_t im, input vec_t rf);
    case (s)
      2'd0:    return p0;
      2'd1:    return p1;
      2'd2:    return im;
      default: return rf;
    endcase
  endfunction

  // Beats pass each stage in order, so walking one beat through every stage at acceptance
  // time sees the same register-file contents the hardware sees.
  function automatic vec_t model_beat(input vec_t d, input vec_t x);
    vec_t prev, cur, p0, p1, a, b;
    prev = '0;
    cur  = '0;
    for (int s = 0; s < NS; s++) begin
      if (s == 0) begin
        p0 = d;
        p1 = x;
      end else begin
        p0 = prev;
        for (int i = 0; i < LN; i++) p1[i*LW +: LW] = prev[((i + LN - 1) % LN)*LW +: LW];
      end
      a = operand(c_sel[s][1:0], p0, p1, {LN{c_imm[s]}}, mrf[s][c_rd[s]]);
      b = operand(c_sel[s][3:2], p0, p1, {LN{c_imm[s]}}, mrf[s][c_rd[s]]);
      for (int i = 0; i < LN; i++) cur[i*LW +: LW] = alu_ref(a[i*LW +: LW], b[i*LW +: LW], c_op[s]);
      if (c_wen[s]) mrf[s][c_wr[s]] = cur;
      prev = cur;
    end
    return prev;
  endfunction

  task automatic clear_model();
    for (int s = 0; s < NS; s++)
      for (int a = 0; a < RD; a++) mrf[s][a] = '0;
    exp_q.delete();
    acc_q.delete();
    out_log.delete();
  endtask

  task automatic set_pass();
    for (int s = 0; s < NS; s++) begin
      c_sel[s] = 4'b1000;
      c_op[s]  = 2'b00;
      c_imm[s] = '0;
      c_wen[s] = 1'b0;
      c_rd[s]  = '0;
      c_wr[s]  = '0;
    end
  endtask

  task automatic rand_cfg();
    for (int s = 0; s < NS; s++) begin
      c_sel[s] = 4'($urandom);
      c_op[s]  = 2'($urandom);
      c_imm[s] = rnd_lane();
      c_wen[s] = 1'($urandom_range(1));
      c_rd[s]  = AW'($urandom_range(3));
      c_wr[s]  = AW'($urandom_range(3));
    end
  endtask

  task automatic one_beat(input vec_t d, input vec_t x);
    stim_d.push_back(d);
    stim_a.push_back(x);
  endtask

  task automatic run(input int vpct, input int rpct, input bit stall_win);
    int   cyc, lat;
    bit   pend, stalled;
    vec_t held, got;
    cyc = 0; pend = 1'b0; stalled = 1'b0; held = '0;
    while ((stim_d.size() > 0 || pend || exp_q.size() > 0) && cyc < CYC_LIMIT) begin
      @(negedge clk);
      if (!pend && stim_d.size() > 0 && int'($urandom_range(99)) < vpct) begin
        in_data = stim_d.pop_front();
        in_aux  = stim_a.pop_front();
        pend    = 1'b1;
      end
      in_valid  = pend;
      out_ready = stall_win ? !(cyc >= 3 && cyc <= 7) : (int'($urandom_range(99)) < rpct);
      #1;
      chk1("in_ready", in_ready, !(exp_q.size() == NS && !out_ready));
      if (stalled) chk("hold_data", out_data, held);
      if (out_valid) begin
        chk1("no_dup", exp_q.size() != 0, 1'b1);
        if (out_ready && exp_q.size() != 0) begin
          got = out_data;
          chk("out_data", got, exp_q.pop_front());
          out_log.push_back(got);
          lat = cyc - acc_q.pop_front();
          if (rpct == 100 && !stall_win) chk("latency", VW'(lat), VW'(NS));
        end
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (in_valid && in_ready) begin
        exp_q.push_back(model_beat(in_data, in_aux));
        acc_q.push_back(cyc);
        pend = 1'b0;
      end
      cyc++;
    end
    chk1("run_bound", cyc < CYC_LIMIT, 1'b1);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk1("drained", out_valid, 1'b0);
  endtask

  initial begin
    vec_t rot_exp;
    set_pass();
    clear_model();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk1("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_data", out_data, '0);
    chk1("reset_in_ready", in_ready, 1'b1);

    // Straight pass-through of lanes 1..8 with latency NS.
    set_pass();
    c_sel[0] = 4'b0100;
    one_beat(ramp(1), '0);
    run(100, 100, 1'b0);
    chk("pass_through", out_log.pop_front(), ramp(1));

    // 3 - 5 at stage 0, carried through unchanged.
    set_pass();
    c_imm[0] = 64'd5;
    c_op[0]  = 2'b01;
    one_beat(rep(64'd3), '0);
    run(100, 100, 1'b0);
    chk("sub_imm", out_log.pop_front(), rep(64'hFFFF_FFFF_FFFF_FFFE));

    // Lane rotation at stage 1.
    set_pass();
    c_sel[1] = 4'b1001;
    for (int i = 0; i < LN; i++) rot_exp[i*LW +: LW] = LW'((i + LN - 1) % LN);
    one_beat(ramp(0), '0);
    run(100, 100, 1'b0);
    chk("rotate", out_log.pop_front(), rot_exp);

    // Register file: write 9, read it back, then same-cycle read/write of one address.
    set_pass();
    c_wen[0] = 1'b1;
    c_wr[0]  = 4'd2;
    one_beat(rep(64'd9), '0);
    run(100, 100, 1'b0);
    chk("rf_write", out_log.pop_front(), rep(64'd9));
    set_pass();
    c_sel[0] = 4'b1100;
    c_rd[0]  = 4'd2;
    one_beat(rep(64'd1), '0);
    run(100, 100, 1'b0);
    chk("rf_read", out_log.pop_front(), rep(64'd10));
    c_wen[0] = 1'b1;
    c_wr[0]  = 4'd2;
    one_beat(rep(64'd1), '0);
    one_beat(rep(64'd1), '0);
    run(100, 100, 1'b0);
    chk("rf_same_cycle_old", out_log.pop_front(), rep(64'd10));
    chk("rf_next_beat_new", out_log.pop_front(), rep(64'd11));

    // Overflow at the signed extremes.
    set_pass();
    c_imm[0] = 64'd1;
    one_beat(rep(MAXL), '0);
    run(100, 100, 1'b0);
`ifdef SIMD_PIPE_SAT_EN
    chk("add_overflow", out_log.pop_front(), rep(MAXL));
`else
    chk("add_overflow", out_log.pop_front(), rep(MINL));
`endif
    c_op[0] = 2'b01;
    one_beat(rep(MINL), '0);
    run(100, 100, 1'b0);
`ifdef SIMD_PIPE_SAT_EN
    chk("sub_underflow", out_log.pop_front(), rep(MINL));
`else
    chk("sub_underflow", out_log.pop_front(), rep(MAXL));
`endif

    // Ten back-to-back beats with the output stalled for cycles 3..7.
    set_pass();
    out_log.delete();
    for (int k = 0; k < 10; k++) one_beat(ramp(16 * k), '0);
    run(100, 100, 1'b1);
    chk("stall_count", VW'(out_log.size()), VW'(10));
    for (int k = 0; k < 10 && out_log.size() > 0; k++) chk("stall_order", out_log.pop_front(), ramp(16 * k));

    // Random configurations and traffic.
    for (int ph = 0; ph < 6; ph++) begin
      rand_cfg();
      out_log.delete();
      for (int k = 0; k < 25; k++) one_beat(rnd_vec(), rnd_vec());
      run(ph == 0 ? 100 : 70, ph == 0 ? 100 : 60, 1'b0);
    end

    // Reset in the middle of a stream with stage-0 RF writes in flight.
    set_pass();
    c_wen[0] = 1'b1;
    c_wr[0]  = 4'd5;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = rep(64'd77);
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("rst_mid_out_valid", out_valid, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b0;
    #1;
    chk1("rst_mid_out_valid_after", out_valid, 1'b0);
    chk("rst_mid_out_data", out_data, '0);
    chk1("rst_mid_in_ready", in_ready, 1'b1);
    clear_model();
    set_pass();
    c_sel[0] = 4'b1110;
    c_rd[0]  = 4'd5;
    one_beat(rep(64'd3), '0);
    run(100, 100, 1'b0);
    chk("rst_rf_cleared", out_log.pop_front(), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
